// File: rtl/figan_pkg.sv
// Shared definitions for the figan layer sequencers: default number format,
// sequencer state encoding and the common rescale/saturate rule.
package figan_pkg;

    localparam int FIGAN_DATA_WIDTH = 16;
    localparam int FIGAN_FRAC_BITS  = 10;

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        BIAS = 2'd1,
        OUT  = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [63:0] value;
        logic               sat;
    } rescale_t;

    // Arithmetic right shift (floor toward -inf), then clip to a signed data_width range.
    function automatic rescale_t shift_sat(input logic signed [63:0] acc,
                                           input int frac_bits,
                                           input int data_width);
        rescale_t           r;
        logic signed [63:0] shifted;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        shifted = acc >>> frac_bits;
        hi      = (64'sd1 <<< (data_width - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (data_width - 1));
        r.value = shifted;
        r.sat   = 1'b0;
        if (shifted > hi) begin
            r.value = hi;
            r.sat   = 1'b1;
        end else if (shifted < lo) begin
            r.value = lo;
            r.sat   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/q_rescale_sat.sv
// Combinational accumulator-to-output conversion: shift out the fraction,
// saturate to DATA_WIDTH and optionally clamp negatives to zero.
module q_rescale_sat
    import figan_pkg::*;
#(
    parameter int ACC_WIDTH  = 40,
    parameter int DATA_WIDTH = FIGAN_DATA_WIDTH,
    parameter int FRAC_BITS  = FIGAN_FRAC_BITS,
    parameter int RELU       = 0
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    output logic signed [DATA_WIDTH-1:0] data,
    output logic                         sat
);

    rescale_t res;
    logic     unused_bits;

    // The saturated value always fits DATA_WIDTH; only the sign bit above it matters.
    assign unused_bits = ^res.value[62:DATA_WIDTH];

    always_comb begin
        res  = shift_sat(64'(acc), FRAC_BITS, DATA_WIDTH);
        data = res.value[DATA_WIDTH-1:0];
        sat  = res.sat;
        if (RELU != 0 && res.value[63]) begin
            data = '0;
        end
    end

endmodule

// File: rtl/dec2_mac_seq.sv
// dec2 output-neuron sequencer: N_IN multiply-accumulate beats through one
// multiplier, bias add, rescale/saturate, then a valid/ready result.
module dec2_mac_seq
    import figan_pkg::*;
#(
    parameter int DATA_WIDTH = FIGAN_DATA_WIDTH,
    parameter int FRAC_BITS  = FIGAN_FRAC_BITS,
    parameter int N_IN       = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int RELU       = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         x_valid,
    output logic                         x_ready,
    input  logic signed [DATA_WIDTH-1:0] x_data,
    output logic [$clog2(N_IN)-1:0]      w_sel,
    input  logic signed [DATA_WIDTH-1:0] w_in,
    input  logic signed [DATA_WIDTH-1:0] bias_in,
    output logic                         y_valid,
    input  logic                         y_ready,
    output logic signed [DATA_WIDTH-1:0] y_data,
    output logic                         y_sat,
    output state_t                       state
);

    localparam int CW = $clog2(N_IN);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and y_* stay stable while y_valid && !y_ready.

    state_t                         state_q;
    state_t                         state_d;
    logic [CW-1:0]                  cnt;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [ACC_WIDTH-1:0]    acc_biased;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [DATA_WIDTH-1:0]   res_data;
    logic                           res_sat;
    logic                           beat;
    logic                           last_beat;

    assign prod       = x_data * w_in;
    assign acc_biased = acc + (ACC_WIDTH'(bias_in) <<< FRAC_BITS);
    assign x_ready    = rst_n && (state_q == ACC);
    assign beat       = x_valid && x_ready;
    assign last_beat  = beat && (cnt == CW'(N_IN - 1));
    assign y_valid    = (state_q == OUT);
    assign w_sel      = cnt;
    assign state      = state_q;

    q_rescale_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .RELU      (RELU)
    ) u_rescale (
        .acc (acc_biased),
        .data(res_data),
        .sat (res_sat)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (last_beat) state_d = BIAS;
            BIAS:    state_d = OUT;
            OUT:     if (y_ready) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACC;
            cnt     <= '0;
            acc     <= '0;
            y_data  <= '0;
            y_sat   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ACC: begin
                    if (beat) begin
                        acc <= acc + ACC_WIDTH'(prod);
                        cnt <= last_beat ? '0 : cnt + 1'b1;
                    end
                end
                BIAS: begin
                    acc    <= acc_biased;
                    y_data <= res_data;
                    y_sat  <= res_sat;
                end
                OUT: begin
                    if (y_ready) begin
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dec2_mac_seq.md
# dec2_mac_seq

Sequencer for one dec2 output neuron. It streams 16 fixed-point activations through a single shared multiplier, and for each beat it selects the matching weight from the dec2 weight ROM by index. After the last beat it adds the bias, rescales, saturates and hands the result downstream over a valid/ready handshake. It sits between the previous layer's activation stream and the next decoder stage, and owns the weight-index sequencing for the dec2 ROM.

## Interface
- DATA_WIDTH, 16, width of activations, weights, bias and result (signed, Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS).
- FRAC_BITS, 10, fractional bits of every operand.
- N_IN, 16, activations/weights per neuron.
- ACC_WIDTH, 40, accumulator width; must be ≥ 2*DATA_WIDTH + $clog2(N_IN) + 1.
- RELU, 0, 1 = clamp negative results to 0 after saturation.

Ports:
- clk  in  1  the single clock; all state changes on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- x_valid  in  1  activation beat valid.
- x_ready  out  1  block accepts a beat.
- x_data  in  DATA_WIDTH  signed activation.
- w_sel  out  $clog2(N_IN)  weight index to ROM mux; equals beat counter.
- w_in  in  DATA_WIDTH  signed weight for w_sel; ROM is combinational, so w_in is valid in the same cycle.
- bias_in  in  DATA_WIDTH  signed bias; constant.
- y_valid  out  1  result valid.
- y_ready  in  1  downstream accepts.
- y_data  out  DATA_WIDTH  signed result.
- y_sat  out  1  saturation occurred for the current y_data; qualified by y_valid.

## Operation
- States: ACC, BIAS, OUT.
- **ACC**
  - x_ready=1.
  - On x_valid&x_ready: acc += sext(x_data)*sext(w_in) at full precision; cnt++.
  - When the beat with cnt==N_IN-1 is accepted: go to BIAS, cnt→0.
- **BIAS**
  - x_ready=0.
  - acc += sext(bias_in) <<< FRAC_BITS.
  - r = acc >>> FRAC_BITS (arithmetic shift, floor toward −∞).
  - Saturate r to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1]; y_sat=1 if clipped.
  - If RELU: negative → 0.
  - Register the result into y_data, set y_valid=1, go to OUT.
- **OUT**
  - x_ready=0.
  - y_valid, y_data, y_sat held stable until y_ready.
  - On y_valid&y_ready: y_valid→0, acc→0, cnt→0, go to ACC.
- w_sel = cnt in every state.
- Outside OUT, y_data holds its last value; there is no bubble-free overlap between frames.
- x_data, w_in and bias_in are ignored when they are not being consumed.

## Timing
- Reset (rst_n=0 at an edge) forces:
  - state=ACC, cnt=0, acc=0.
  - y_valid=0, y_data=0, y_sat=0.
  - x_ready=1 from the first cycle after reset release.
  - w_sel=0.
- Reset mid-frame discards the partial sum. Beats already accepted are lost; the next accepted beat is index 0.
- Reset while in OUT drops the pending result.
- Latency: last beat accepted at edge t; BIAS during cycle t+1; y_valid=1 from edge t+2.
- y_ready may be high before y_valid. The handshake completes on the first cycle y_valid=1, so the minimum OUT time is 1 cycle.
- After the y handshake at edge u, x_ready=1 during cycle u+1.
- Frame period ≥ N_IN+2 cycles.
- Gaps in x_valid stall cnt without losing state.

## Structure
- Shared package figan_pkg holds:
  - DATA_WIDTH and FRAC_BITS defaults.
  - The state enum {ACC, BIAS, OUT}.
  - A function for the arithmetic-shift-and-saturate rule, reused by other layer sequencers.
- One sub-module is natural: q_rescale_sat (ACC_WIDTH in → DATA_WIDTH out plus sat flag; combinational shift, saturate, optional ReLU).
- The weight ROM is instantiated by the parent and connected via w_sel/w_in; it is not inside this block.

## Test plan
- **Nominal:** all x=0x0400 (1.0), ROM returns 0x0100 (0.25) for every index, bias=0x0001 → y_data=0x1001, y_sat=0, y_valid at t+2; w_sel steps 0..15.
- **Positive saturation:** x=0x7FFF, w=0x7FFF, bias 0 → y_data=0x7FFF, y_sat=1. Negative saturation: x=0x8000, w=0x7FFF → y_data=0x8000, y_sat=1. With RELU=1, the negative case gives 0x0000.
- **Floor rounding:** x=0xFFFF, w=0x0001 ×16, bias 0 → acc=−16, y_data=0xFFFF. Same with x=0x0001 → 0x0000.
- **Backpressure and gaps:**
  - Random x_valid gaps give a result identical to the gap-free run.
  - Hold y_ready=0 for 5 cycles: y_valid, y_data and y_sat stay stable and x_ready=0.
  - After the handshake, x_ready=1 next cycle.
- **Reset mid-frame:** accept 7 beats of 0x0400, pulse rst_n=0 for one cycle, then a full frame of 0x0200 with w=0x0100 and bias 0 → y_data=0x0800. All outputs read 0 during reset.
- **Back-to-back frames** with y_ready tied high → each result is correct and period = N_IN+2 cycles.
